ook_frame_sequencer: RTL and testbench

//  Frames and sequences the 16-bit GT TX word stream on the TX user clock (gt0_txusrclk2 domain).

---
 rtl/ook_frame_pkg.sv | 22 ++
 rtl/ook_frame_sequencer_if.sv | 21 ++
 rtl/ook_crc16_step.sv | 24 ++
 rtl/ook_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_ook_frame_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ook_frame_pkg.sv
// Shared types and constants for the OOK frame sequencer.
// CRC constants are used only when OOK_FRAME_CRC_EN is defined.
package ook_frame_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t CRC_POLY = 16'h1021;
  localparam word_t CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_LEN,
    ST_PAY,
    ST_CRC,
    ST_GUARD
  } state_t;

endpackage

// File: rtl/ook_frame_sequencer_if.sv
// Payload stream handshake between the PRBS source and the sequencer.
// A word moves when pl_valid and pl_ready are both high.
interface ook_frame_sequencer_if;

  logic [15:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;

  modport master (
    output pl_data,
    output pl_valid,
    input  pl_ready
  );

  modport slave (
    input  pl_data,
    input  pl_valid,
    output pl_ready
  );

endinterface

// File: rtl/ook_crc16_step.sv
// One-clock CRC-16-CCITT update over a 16-bit word, MSB first.
// Purely combinational; poly 0x1021, no reflection.
module ook_crc16_step
  import ook_frame_pkg::*;
(
  input  word_t crc_in,
  input  word_t data_in,
  output word_t crc_out
);

  word_t c;

  always_comb begin
    c = crc_in;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[15] ^ data_in[i])
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      else
        c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/ook_frame_sequencer.sv
// Frames the GT TX word stream: preamble, sync, length, payload, guard.
// Define OOK_FRAME_CRC_EN to append a CRC-16-CCITT word after the payload.
module ook_frame_sequencer
  import ook_frame_pkg::*;
#(
  parameter int    PREAMBLE_WORDS = 8,
  parameter word_t PREAMBLE_WORD  = 16'hAAAA,
  parameter word_t SYNC_WORD      = 16'hE5C3,
  parameter int    GUARD_WORDS    = 4,
  parameter word_t IDLE_WORD      = 16'h0000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  gt_tx_ready,
  input  logic  send_req,
  input  word_t frame_len,
  ook_frame_sequencer_if.slave pl,
  output word_t tx_data,
  output logic  busy,
  output logic  frame_done,
  output logic  frame_abort,
  output logic  underrun,
  output word_t frame_cnt
);

  state_t state, state_nxt;
  word_t  cnt, len_q;
  logic   pending;
  logic   start, abort, last, done_nxt;
  word_t  pay_word, word_nxt;

  assign start = (state == ST_IDLE) &&
                 (send_req || pending) && gt_tx_ready;
  assign abort = (state != ST_IDLE) && !gt_tx_ready;

  assign pay_word = pl.pl_valid ? pl.pl_data : IDLE_WORD;
  assign done_nxt = (state == ST_GUARD) && last && !abort;

  always_comb begin
    last = 1'b1;
    unique case (state)
      ST_PRE:   last = (cnt == 16'(PREAMBLE_WORDS - 1));
      ST_PAY:   last = (cnt == len_q - 16'd1);
      ST_GUARD: last = (cnt == 16'(GUARD_WORDS - 1));
      default:  last = 1'b1;
    endcase
  end

`ifdef OOK_FRAME_CRC_EN
  localparam state_t ST_AFTER = ST_CRC;

  word_t crc, crc_nxt, crc_din;

  assign crc_din = (state == ST_LEN) ? len_q : pay_word;

  ook_crc16_step u_crc (
    .crc_in  (crc),
    .data_in (crc_din),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= CRC_INIT;
    else if (start)
      crc <= CRC_INIT;
    else if (!abort &&
             (state == ST_LEN || state == ST_PAY))
      crc <= crc_nxt;
  end
`else
  localparam state_t ST_AFTER = ST_GUARD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) state_nxt = ST_PRE;
        ST_PRE:   if (last) state_nxt = ST_SYNC;
        ST_SYNC:  state_nxt = ST_LEN;
        ST_LEN:   state_nxt = (len_q == '0) ?
                              ST_AFTER : ST_PAY;
        ST_PAY:   if (last) state_nxt = ST_AFTER;
        ST_CRC:   state_nxt = ST_GUARD;
        ST_GUARD: if (last) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    pl.pl_ready = (state == ST_PAY) && gt_tx_ready;
    word_nxt    = IDLE_WORD;
    unique case (state)
      ST_PRE:  word_nxt = PREAMBLE_WORD;
      ST_SYNC: word_nxt = SYNC_WORD;
      ST_LEN:  word_nxt = len_q;
      ST_PAY:  word_nxt = pay_word;
`ifdef OOK_FRAME_CRC_EN
      ST_CRC:  word_nxt = crc;
`endif
      default: word_nxt = IDLE_WORD;
    endcase
    if (abort)
      word_nxt = IDLE_WORD;
  end

  // cnt restarts on every state change so each state counts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data     <= IDLE_WORD;
      cnt         <= '0;
      len_q       <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      tx_data     <= word_nxt;
      frame_done  <= done_nxt;
      frame_abort <= abort;
      if (state_nxt != state || state == ST_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (done_nxt)
        frame_cnt <= frame_cnt + 16'd1;
      if (start)
        len_q <= frame_len;
      if (start)
        underrun <= 1'b0;
      else if (state == ST_PAY && !abort &&
               !pl.pl_valid)
        underrun <= 1'b1;
      if (start || abort)
        pending <= 1'b0;
      else if (send_req)
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ook_frame_sequencer.sv
// Scoreboard bench for ook_frame_sequencer.
// Honours OOK_FRAME_CRC_EN when building expected frames.
module tb_ook_frame_sequencer;
  import ook_frame_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  gt_tx_ready = 1'b1;
  logic  send_req = 1'b0;
  word_t frame_len = '0;
  word_t tx_data, frame_cnt;
  logic  busy, frame_done, frame_abort, underrun;

  ook_frame_sequencer_if pl_if ();

  ook_frame_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gt_tx_ready (gt_tx_ready),
    .send_req    (send_req),
    .frame_len   (frame_len),
    .pl          (pl_if.slave),
    .tx_data     (tx_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .underrun    (underrun),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int extra_ready = 0;
  int mon_left = 0;
  int frames_seen = 0;
  word_t exp_cnt = '0;
  word_t exp_w;
  word_t exp_q[$];
  int len_q[$];
  logic [16:0] src_q[$];

`ifdef OOK_FRAME_CRC_EN
  localparam int CRC_WORDS = 1;
  function automatic word_t crc_upd(input word_t c,
                                    input word_t d);
    word_t r;
    r = c;
    for (int b = 1; b >= 0; b--) begin
      r = r ^ {d[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++)
        r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021)
                  : {r[14:0], 1'b0};
    end
    return r;
  endfunction
`else
  localparam int CRC_WORDS = 0;
`endif

  // payload source: one table entry per PAYLOAD cycle
  initial begin
    logic [16:0] e;
    pl_if.pl_data  = 16'hDEAD;
    pl_if.pl_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pl_if.pl_ready) begin
        if (src_q.size() > 0) begin
          e = src_q.pop_front();
          pl_if.pl_valid = e[16];
          pl_if.pl_data  = e[15:0];
        end else begin
          extra_ready++;
          pl_if.pl_valid = 1'b1;
          pl_if.pl_data  = 16'h5A5A;
        end
      end else begin
        pl_if.pl_valid = 1'b1;
        pl_if.pl_data  = 16'hDEAD;
      end
    end
  end

  // line monitor: a queued frame begins at its first preamble word
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_left = 0;
      end else begin
        if (mon_left == 0 && len_q.size() > 0 &&
            tx_data === 16'hAAAA)
          mon_left = len_q.pop_front();
        if (mon_left > 0) begin
          exp_w = exp_q.pop_front();
          n_chk++;
          if (tx_data !== exp_w) begin
            n_fail++;
            $display("FAIL word: tx_data=%h required %h",
                     tx_data, exp_w);
          end
          mon_left--;
          n_chk++;
          if (frame_done !== (mon_left == 0)) begin
            n_fail++;
            $display("FAIL done_pulse: frame_done=%b required %b",
                     frame_done, mon_left == 0);
          end
          if (mon_left == 0) frames_seen++;
        end
      end
    end
  end

  task automatic queue_frame(input word_t len,
                             input int bad_idx);
    word_t d, w;
`ifdef OOK_FRAME_CRC_EN
    word_t crc;
    crc = 16'hFFFF;
    crc = crc_upd(crc, len);
`endif
    repeat (8) exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hE5C3);
    exp_q.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      d = 16'(i + 1);
      src_q.push_back({i != bad_idx, d});
      w = (i != bad_idx) ? d : 16'h0000;
      exp_q.push_back(w);
`ifdef OOK_FRAME_CRC_EN
      crc = crc_upd(crc, w);
`endif
    end
`ifdef OOK_FRAME_CRC_EN
    exp_q.push_back(crc);
`endif
    repeat (4) exp_q.push_back(16'h0000);
    len_q.push_back(14 + int'(len) + CRC_WORDS);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic pulse_send;
    @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && len_q.size() == 0 &&
          mon_left == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: %0d words pending, required 0",
               exp_q.size());
    end
  endtask

  task automatic check_cnt(input string tag);
    n_chk++;
    if (frame_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s: frame_cnt=%0d required %0d",
               tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      send_req = (i % 2 == 0);
      @(posedge clk);
      #1;
      n_chk++;
      if (tx_data !== 16'h0 || busy !== 1'b0 ||
          frame_cnt !== 16'h0 || underrun !== 1'b0 ||
          pl_if.pl_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: tx=%h busy=%b cnt=%0d, required 0",
                 tx_data, busy, frame_cnt);
      end
    end
    @(negedge clk);
    send_req = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pending: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic;
    frame_len = 16'd3;
    queue_frame(16'd3, -1);
    @(negedge clk);
    send_req = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || tx_data !== 16'h0) begin
      n_fail++;
      $display("FAIL start_edge: busy=%b tx=%h required 1 0000",
               busy, tx_data);
    end
    @(negedge clk);
    send_req = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (tx_data !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL first_pre: tx=%h required aaaa", tx_data);
    end
    wait_idle(200);
    check_cnt("basic_cnt");
    n_chk++;
    if (underrun !== 1'b0 || extra_ready != 0) begin
      n_fail++;
      $display("FAIL basic_flags: underrun=%b extra=%0d required 0 0",
               underrun, extra_ready);
    end
  endtask

  task automatic test_underrun;
    frame_len = 16'd4;
    queue_frame(16'd4, 1);
    pulse_send();
    wait_idle(200);
    check_cnt("underrun_cnt");
    n_chk++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky: underrun=%b required 1",
               underrun);
    end
  endtask

  task automatic test_zero_len;
    frame_len = 16'd0;
    queue_frame(16'd0, -1);
    @(negedge clk);
    send_req = 1'b1;
    @(posedge clk);
    #2;
    n_chk++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: underrun=%b required 0",
               underrun);
    end
    @(negedge clk);
    send_req = 1'b0;
    wait_idle(200);
    check_cnt("zero_cnt");
    n_chk++;
    if (extra_ready != 0) begin
      n_fail++;
      $display("FAIL zero_ready: extra accepts=%0d required 0",
               extra_ready);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = frames_seen;
    frame_len = 16'd2;
    queue_frame(16'd2, -1);
    queue_frame(16'd2, -1);
    pulse_send();
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      pulse_send();
    end
    wait_idle(300);
    repeat (30) @(posedge clk);
    #1;
    check_cnt("b2b_cnt");
    n_chk++;
    if (frames_seen - f0 != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_frames: seen=%0d busy=%b required 2 0",
               frames_seen - f0, busy);
    end
  endtask

  task automatic test_abort;
    bit hit;
    frame_len = 16'd6;
    for (int i = 0; i < 6; i++)
      src_q.push_back({1'b1, 16'(i + 1)});
    pulse_send();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pl_if.pl_ready) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach: pl_ready never 1, required 1");
    end
    @(negedge clk);
    gt_tx_ready = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (tx_data !== 16'h0 || frame_abort !== 1'b1 ||
        busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: tx=%h abort=%b busy=%b required 0000 1 0",
               tx_data, frame_abort, busy);
    end
    check_cnt("abort_cnt");
    @(posedge clk);
    #1;
    n_chk++;
    if (frame_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse: abort=%b required 0", frame_abort);
    end
    src_q.delete();
    extra_ready = 0;
    // request while the GT is not ready waits for ready
    frame_len = 16'd1;
    queue_frame(16'd1, -1);
    pulse_send();
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_wait: busy=%b required 0", busy);
    end
    @(negedge clk);
    gt_tx_ready = 1'b1;
    wait_idle(200);
    check_cnt("pend_cnt");
    frame_len = 16'd5;
    for (int i = 0; i < 5; i++)
      src_q.push_back({1'b1, 16'(i + 1)});
    pulse_send();
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (tx_data !== 16'h0 || busy !== 1'b0 ||
        frame_cnt !== 16'h0 || underrun !== 1'b0 ||
        frame_abort !== 1'b0 || frame_done !== 1'b0 ||
        pl_if.pl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: tx=%h busy=%b cnt=%0d required 0",
               tx_data, busy, frame_cnt);
    end
    src_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_zero_len();
    test_back_to_back();
    test_abort();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d words unseen, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
